// File: rtl/sbox_share_ctrl.sv
// Shares one combinational byte-substitution lookup between the round datapath (ST, 16 B)
// and key expansion (KS, 4 B). Each request is streamed LANES bytes/cycle and returned whole.

module sbox_share_lane #(
  parameter int BUF_BYTES = 16,
  parameter int IW        = 4,
  parameter int LANE      = 0
) (
  input  logic                   i_en,
  input  logic [8*BUF_BYTES-1:0] i_buf,
  input  logic [IW-1:0]          i_base,
  output logic [7:0]             o_byte
);
  assign o_byte = i_en ? i_buf[(int'(i_base) + LANE)*8 +: 8] : 8'h00;
endmodule

module sbox_share_ctrl #(
  parameter int LANES    = 4,
  parameter int ST_BYTES = 16,
  parameter int KS_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_req_valid,
  input  logic [8*ST_BYTES-1:0] st_req_data,
  output logic                  st_req_ready,
  output logic                  st_rsp_valid,
  output logic [8*ST_BYTES-1:0] st_rsp_data,
  input  logic                  st_rsp_ready,
  input  logic                  ks_req_valid,
  input  logic [8*KS_BYTES-1:0] ks_req_data,
  output logic                  ks_req_ready,
  output logic                  ks_rsp_valid,
  output logic [8*KS_BYTES-1:0] ks_rsp_data,
  input  logic                  ks_rsp_ready,
  output logic                  sbox_en,
  output logic [8*LANES-1:0]    sbox_lane_in,
  input  logic [8*LANES-1:0]    sbox_lane_out,
  output logic                  busy,
  output logic                  owner
);
  localparam int ST_BEATS = ST_BYTES / LANES;
  localparam int KS_BEATS = KS_BYTES / LANES;
  localparam int BW       = $clog2(ST_BEATS + 1);
  localparam int IW       = $clog2(ST_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [BW-1:0]         r_beat;
  logic [BW-1:0]         r_beats;
  logic                  r_owner;
  logic                  r_last;
  logic [8*ST_BYTES-1:0] r_buf;
  logic [8*ST_BYTES-1:0] r_res;

  logic          w_idle, w_run, w_resp;
  logic          w_gnt_st, w_gnt_ks, w_acc, w_rsp_hs;
  logic [IW-1:0] w_base;

  // Ready is masked while reset is held so a waiting requester sees no grant.
  assign w_idle = (r_state == S_IDLE) & ~reset;
  assign w_run  = (r_state == S_RUN);
  assign w_resp = (r_state == S_RESP);

  // On a tie the requester that did not win last time gets the lookup.
  assign w_gnt_st = w_idle & st_req_valid & (~ks_req_valid | r_last);
  assign w_gnt_ks = w_idle & ks_req_valid & (~st_req_valid | ~r_last);
  assign w_acc    = w_gnt_st | w_gnt_ks;

  assign w_base = IW'(int'(r_beat) * LANES);

  assign st_req_ready = w_gnt_st;
  assign ks_req_ready = w_gnt_ks;
  assign st_rsp_valid = w_resp & ~r_owner;
  assign ks_rsp_valid = w_resp & r_owner;
  assign st_rsp_data  = st_rsp_valid ? r_res : '0;
  assign ks_rsp_data  = ks_rsp_valid ? r_res[8*KS_BYTES-1:0] : '0;
  assign w_rsp_hs     = (st_rsp_valid & st_rsp_ready) | (ks_rsp_valid & ks_rsp_ready);

  assign sbox_en = w_run;
  assign busy    = (r_state != S_IDLE);
  assign owner   = r_owner;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_share_lane #(
      .BUF_BYTES(ST_BYTES),
      .IW       (IW),
      .LANE     (g)
    ) u_lane (
      .i_en  (w_run),
      .i_buf (r_buf),
      .i_base(w_base),
      .o_byte(sbox_lane_in[g*8 +: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_beats <= '0;
      r_owner <= 1'b1;
      r_last  <= 1'b1;
      r_buf   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_buf   <= w_gnt_st ? st_req_data
                                : {{(8*(ST_BYTES-KS_BYTES)){1'b0}}, ks_req_data};
            r_owner <= w_gnt_ks;
            r_beats <= w_gnt_st ? BW'(ST_BEATS) : BW'(KS_BEATS);
            r_beat  <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++)
            r_res[(int'(w_base) + l)*8 +: 8] <= sbox_lane_out[l*8 +: 8];
          r_beat <= r_beat + BW'(1);
          if (r_beat == r_beats - BW'(1))
            r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: AES S-box as the lookup, directed vector table, corner-case
// sequences, and a transaction-level random reference model. A second LANES=1 instance is included.

module tb_sbox_share_ctrl;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         st_v, st_rdy, st_rv, st_rr, ks_v, ks_rdy, ks_rv, ks_rr, en, busy, owner;
  logic [127:0] st_d, st_rd;
  logic [31:0]  ks_d, ks_rd, lin, lout;

  logic         b_st_v, b_st_rdy, b_st_rv, b_st_rr, b_ks_v, b_ks_rdy, b_ks_rv, b_ks_rr, b_en, b_busy, b_owner;
  logic [127:0] b_st_d, b_st_rd;
  logic [31:0]  b_ks_d, b_ks_rd;
  logic [7:0]   b_lin, b_lout;

  sbox_share_ctrl #(.LANES(4)) u4 (
    .clk(clk), .reset(reset),
    .st_req_valid(st_v), .st_req_data(st_d), .st_req_ready(st_rdy),
    .st_rsp_valid(st_rv), .st_rsp_data(st_rd), .st_rsp_ready(st_rr),
    .ks_req_valid(ks_v), .ks_req_data(ks_d), .ks_req_ready(ks_rdy),
    .ks_rsp_valid(ks_rv), .ks_rsp_data(ks_rd), .ks_rsp_ready(ks_rr),
    .sbox_en(en), .sbox_lane_in(lin), .sbox_lane_out(lout),
    .busy(busy), .owner(owner));

  sbox_share_ctrl #(.LANES(1)) u1 (
    .clk(clk), .reset(reset),
    .st_req_valid(b_st_v), .st_req_data(b_st_d), .st_req_ready(b_st_rdy),
    .st_rsp_valid(b_st_rv), .st_rsp_data(b_st_rd), .st_rsp_ready(b_st_rr),
    .ks_req_valid(b_ks_v), .ks_req_data(b_ks_d), .ks_req_ready(b_ks_rdy),
    .ks_rsp_valid(b_ks_rv), .ks_rsp_data(b_ks_rd), .ks_rsp_ready(b_ks_rr),
    .sbox_en(b_en), .sbox_lane_in(b_lin), .sbox_lane_out(b_lout),
    .busy(b_busy), .owner(b_owner));

  always_comb begin
    lout = '0;
    for (int l = 0; l < 4; l++) lout[l*8 +: 8] = SBOX[lin[l*8 +: 8]];
    b_lout = SBOX[b_lin];
  end

  int errs = 0;
  int checks = 0;

  function automatic logic [127:0] sbox_all(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = SBOX[x[k*8 +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Single transaction on u4 (or u1 when d1), response ready held high.
  task automatic run_txn(input bit d1, input bit ks, input logic [127:0] data,
                         input logic [127:0] exp, input int lat, input string nm);
    int encnt = 0;
    int vc = 0;
    bit other = 0;
    logic [127:0] got = '0;
    if (d1)      begin b_st_v = 1; b_st_d = data; b_st_rr = 1; end
    else if (ks) begin ks_v = 1; ks_d = data[31:0]; ks_rr = 1; end
    else         begin st_v = 1; st_d = data; st_rr = 1; end
    @(negedge clk);
    chk({nm, "_ready"}, d1 ? b_st_rdy : (ks ? ks_rdy : st_rdy), 1);
    if (!d1) chk({nm, "_other_ready"}, ks ? st_rdy : ks_rdy, 0);
    @(posedge clk); #1;
    b_st_v = 0; st_v = 0; ks_v = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (d1 ? b_en : en) encnt++;
      if (!d1 && (ks ? (st_rv || st_rd != 0) : (ks_rv || ks_rd != 0))) other = 1;
      if (d1 ? b_st_rv : (ks ? ks_rv : st_rv)) begin
        vc = c;
        got = d1 ? b_st_rd : (ks ? {96'b0, ks_rd} : st_rd);
        break;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_latency"}, vc, lat);
    chk({nm, "_en_cycles"}, encnt, lat - 1);
    chk({nm, "_data"}, got, exp);
    if (!d1) chk({nm, "_other_quiet"}, other, 0);
    @(posedge clk); #1;
    b_st_rr = 0; st_rr = 0; ks_rr = 0;
    @(negedge clk);
    chk({nm, "_idle_after"}, d1 ? b_busy : busy, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit           ks;
    logic [127:0] data;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vt[4];

  initial begin
    int g[$];
    logic [127:0] d0, x;
    bit bad;
    bit           m_active, m_own, m_last;
    int           m_left, beats;
    logic [127:0] m_data, m_exp;
    bit           e_gst, e_gks, e_resp;
    logic [31:0]  e_lin;

    st_v = 0; st_d = '0; st_rr = 0; ks_v = 0; ks_d = '0; ks_rr = 0;
    b_st_v = 0; b_st_d = '0; b_st_rr = 0; b_ks_v = 0; b_ks_d = '0; b_ks_rr = 0;

    vt[0] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63, 5};
    vt[1] = '{1'b1, 128'h10ff5300, 128'hca16ed63, 2};
    vt[2] = '{1'b0, {16{8'h53}}, {16{8'hed}}, 5};
    vt[3] = '{1'b1, 128'h04030201, 128'hf27b777c, 2};

    // Reset state
    @(negedge clk);
    chk("rst_flags", {st_rdy, ks_rdy, st_rv, ks_rv, en, busy}, 0);
    chk("rst_owner", owner, 1);
    chk("rst_lane_in", lin, 0);
    chk("rst_rsp_data", {st_rd, ks_rd}, 0);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 4; i++)
      run_txn(0, vt[i].ks, vt[i].data, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

    // LANES=1 instance: 16 beats, same data as the first vector
    run_txn(1, 0, vt[0].data, vt[0].exp, 17, "lanes1");

    // Both requesters held valid from reset: strict alternation starting with ST
    do_reset();
    st_v = 1; ks_v = 1; st_d = 128'h1; ks_d = 32'h2; st_rr = 1; ks_rr = 1;
    bad = 0;
    for (int c = 0; c < 80 && g.size() < 4; c++) begin
      @(negedge clk);
      if (st_rdy && ks_rdy) bad = 1;
      if (st_rdy) g.push_back(0);
      else if (ks_rdy) g.push_back(1);
      @(posedge clk); #1;
    end
    st_v = 0; ks_v = 0;
    chk("rr_no_double_grant", bad, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), (i < g.size()) ? g[i] : 2, i % 2);
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (!busy) break; end
    chk("rr_drain", busy, 0);
    @(posedge clk); #1;
    st_rr = 0; ks_rr = 0;

    // ST response back-pressured while KS waits
    do_reset();
    x = {$urandom, $urandom, $urandom, $urandom};
    st_v = 1; st_d = x; ks_v = 1; ks_d = 32'h10ff5300;
    @(negedge clk);
    chk("bp_st_granted", {st_rdy, ks_rdy}, 2'b10);
    @(posedge clk); #1;
    st_v = 0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ks_rdy) bad = 1;
      if (st_rv) break;
      @(posedge clk); #1;
    end
    chk("bp_ks_blocked_run", bad, 0);
    chk("bp_st_valid", st_rv, 1);
    d0 = st_rd;
    chk("bp_st_data", d0, sbox_all(x));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) st_rr = 1;
      @(negedge clk);
      chk($sformatf("bp_stable%0d", i), st_rd, d0);
      chk($sformatf("bp_ks_wait%0d", i), {ks_rdy, st_rv}, 2'b01);
    end
    @(posedge clk); #1;
    st_rr = 0;
    @(negedge clk);
    chk("bp_ks_granted_after", {ks_rdy, st_rv}, 2'b10);
    @(posedge clk); #1;
    ks_v = 0; ks_rr = 1;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (ks_rv) break; @(posedge clk); #1; end
    chk("bp_ks_data", {ks_rv, ks_rd}, {1'b1, 32'hca16ed63});
    @(posedge clk); #1;
    ks_rr = 0;

    // Asynchronous reset during RUN beat 2
    st_v = 1; st_d = vt[0].data; st_rr = 1;
    @(negedge clk);
    chk("ar_accept", st_rdy, 1);
    @(posedge clk); #1;
    st_v = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_in_run", en, 1);
    #2;
    reset = 1; st_v = 1;
    #1;
    chk("ar_flags_zero", {st_rdy, ks_rdy, st_rv, ks_rv, en, busy}, 0);
    chk("ar_lanes_zero", {lin, st_rd}, 0);
    chk("ar_owner", owner, 1);
    st_v = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (st_rv || busy) bad = 1;
    end
    chk("ar_no_response", bad, 0);
    @(posedge clk); #1;
    run_txn(0, 0, vt[0].data, vt[0].exp, 5, "ar_reissue");

    // Random traffic against a transaction-level model
    do_reset();
    m_active = 0; m_own = 1; m_last = 1; m_left = 0; m_data = '0; m_exp = '0;
    for (int n = 0; n < 800; n++) begin
      st_v = ($urandom_range(0, 2) != 0);
      ks_v = ($urandom_range(0, 2) != 0);
      st_d = {$urandom, $urandom, $urandom, $urandom};
      ks_d = $urandom;
      st_rr = ($urandom_range(0, 3) != 0);
      ks_rr = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e_gst  = !m_active && st_v && (!ks_v || m_last);
      e_gks  = !m_active && ks_v && (!st_v || !m_last);
      e_resp = m_active && (m_left == 0);
      beats  = m_own ? 1 : 4;
      e_lin  = (m_active && m_left > 0) ? m_data[(beats - m_left)*32 +: 32] : 32'h0;
      chk("rnd_ready", {st_rdy, ks_rdy}, {e_gst, e_gks});
      chk("rnd_rsp_valid", {st_rv, ks_rv}, {e_resp && !m_own, e_resp && m_own});
      chk("rnd_st_data", st_rd, (e_resp && !m_own) ? m_exp : 128'h0);
      chk("rnd_ks_data", ks_rd, (e_resp && m_own) ? m_exp[31:0] : 32'h0);
      chk("rnd_en_busy", {en, busy}, {m_active && m_left > 0, m_active});
      chk("rnd_lane_in", lin, e_lin);
      chk("rnd_owner", owner, m_own);
      if (!m_active) begin
        if (e_gst) begin
          m_active = 1; m_own = 0; m_left = 4; m_data = st_d; m_exp = sbox_all(st_d);
        end else if (e_gks) begin
          m_active = 1; m_own = 1; m_left = 1; m_data = {96'b0, ks_d}; m_exp = sbox_all({96'b0, ks_d});
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (m_own ? ks_rr : st_rr) begin
        m_last = m_own;
        m_active = 0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sbox_share_ctrl.md
Name: sbox_share_ctrl

Overview:
- Sequencer and arbiter that shares one narrow, combinational byte-substitution lookup (LANES bytes per cycle) between two requesters.
- Requester ST is the round datapath: SubBytes on the 16-byte state. Requester KS is key expansion: SubWord on a 4-byte word.
- Each request is accepted whole, streamed through the lookup LANES bytes per cycle, reassembled, and returned on a valid/ready response channel.
- Sits between the round/key-schedule control and the substitution lookup in the encryption core.

Parameters:
- LANES, 4, bytes substituted per cycle. Must divide 4 and 16; legal values are 1, 2, 4.
- ST_BYTES, 16, bytes per ST request (fixed AES state size).
- KS_BYTES, 4, bytes per KS request (fixed AES word size).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_req_valid  in  1  ST request valid.
- st_req_data  in  8*ST_BYTES  ST input bytes; byte k = [8k+7:8k].
- st_req_ready  out  1  ST request accepted this cycle.
- st_rsp_valid  out  1  ST result valid.
- st_rsp_data  out  8*ST_BYTES  substituted ST bytes, same byte order as the request.
- st_rsp_ready  in  1  ST result consumed.
- ks_req_valid  in  1  KS request valid.
- ks_req_data  in  8*KS_BYTES  KS input bytes.
- ks_req_ready  out  1  KS request accepted.
- ks_rsp_valid  out  1  KS result valid.
- ks_rsp_data  out  8*KS_BYTES  substituted KS bytes.
- ks_rsp_ready  in  1  KS result consumed.
- sbox_en  out  1  lookup enable; high only in RUN.
- sbox_lane_in  out  8*LANES  bytes presented to the lookup.
- sbox_lane_out  in  8*LANES  substituted bytes; combinational, valid in the same cycle.
- busy  out  1  high whenever state != IDLE.
- owner  out  1  current or last grant (0 = ST, 1 = KS).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, beat counter=0, last_grant=KS, owner=1.
  - Input buffer and result register cleared to 0.
  - All valid/ready/en outputs 0; rsp_data 0.
  - An in-flight transaction is dropped with no response; the requester must reissue.
- FSM states: IDLE, RUN, RESP.
- IDLE, arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins (round-robin). The first tie after reset goes to ST.
  - The winner's req_ready=1 combinationally in the same cycle; the loser's ready=0. Ready is never high outside IDLE.
- On the accept edge:
  - Capture req_data into the buffer, set owner=winner, set beats=bytes/LANES (ST=16/LANES, KS=4/LANES), beat=0, go to RUN.
- RUN:
  - sbox_en=1; sbox_lane_in lane l = buffer byte beat*LANES+l.
  - Each edge writes sbox_lane_out into result bytes beat*LANES..+LANES-1, then beat increments.
  - After the last beat, go to RESP.
  - New requests are never accepted in RUN; no preemption.
- RESP:
  - The owner's rsp_valid=1; rsp_data driven from the result register, stable while valid.
  - On rsp_valid && rsp_ready: last_grant=owner, go to IDLE. An accept can occur on the next cycle (1 idle cycle minimum between transactions).
  - The non-owner's rsp_valid is always 0.
- Outside RUN: sbox_en=0 and sbox_lane_in=0.
- Latency with LANES=4, measured from the accept edge:
  - ST rsp_valid rises 5 cycles later (4 RUN + 1).
  - KS rsp_valid rises 2 cycles later.
  - In general: bytes/LANES + 1.
- Response backpressure of any length holds RESP indefinitely. Pending requests stay unaccepted.
- Requester valid dropping before accept is legal and has no effect. Data is sampled only on the accept edge.
- Beat counter width is clog2(16/LANES + 1); no wrap occurs because it resets on every accept.

Test Plan:
(Bench models sbox_lane_out with the AES S-box table.)
1. ST only, st_req_data bytes 0x00..0x0F, rsp_ready=1 -> st_req_ready high 1 cycle; sbox_en high exactly 4 cycles; st_rsp_valid 5 cycles after accept; st_rsp_data bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
2. KS only, bytes {0x00,0x53,0xFF,0x10} -> ks_rsp_valid 2 cycles after accept; ks_rsp_data bytes {63,ed,16,ca}; st_* stays 0.
3. Both valid from reset, held -> ST granted first (owner=0). After its response, KS granted; with both re-asserted, the next winner is ST again (strict alternation over 4 transactions).
4. ST in RESP with st_rsp_ready low 3 cycles, KS valid throughout -> st_rsp_data stable for 4 cycles; ks_req_ready stays 0 until the cycle after the ST handshake.
5. Reset asserted during RUN beat 2 -> all outputs 0 immediately (asynchronous); no st_rsp_valid; after release, busy=0, and a reissued request completes with correct data.
6. LANES=1 build, ST request 0x00..0x0F -> 16 RUN cycles; rsp_valid 17 cycles after accept; data identical to scenario 1.
